// File: rtl/arb4rr_pkg.sv
// Shared definitions for the 4-requester round-robin channel arbiter.
// Holds FSM state encodings, requester count and hold-counter width.
// Also provides a one-hot helper used when issuing a grant.
package arb4rr_pkg;

  localparam int NREQ   = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One-hot encode a requester index into a grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
    return NREQ'(1) << i;
  endfunction

endpackage

// File: rtl/arb4rr_pick.sv
// Combinational round-robin picker: first set req bit scanning from ptr upward.
// Latency: zero (pure combinational).
// Backpressure: none; found is low when no bit of req is set.
module rr_pick4
  import arb4rr_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            found,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down to ptr so the nearest set bit wins last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arb4rr.sv
// Round-robin arbiter/sequencer for a shared 4:1 single-bit channel with a hold limit.
// Latency: grant one cycle after req is sampled; release and handover at the same edge.
// Backpressure: requesters wait on level req; a grant is revoked after MAX_HOLD cycles.
module arb4rr
  import arb4rr_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            busy,
  output logic            expired
);

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        owner;
  logic [HOLD_W-1:0] hold;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] pick_ptr;
  logic       owner_req;
  logic       at_limit;
  logic       release_now;

  // The owner is excluded from the release arbitration only by rotating past it;
  // a sole requester therefore wins again at owner+1+3.
  assign pick_ptr    = (state == ST_GRANT) ? (owner + 2'd1) : ptr;
  assign owner_req   = req[owner];
  assign at_limit    = (hold == HOLD_W'(MAX_HOLD));
  assign release_now = (state == ST_GRANT) && (!owner_req || at_limit);
  assign sel         = owner;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Arbitration FSM, hold counter and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= 2'd0;
      owner   <= 2'd0;
      hold    <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state <= ST_GRANT;
            owner <= pick_idx;
            gnt   <= onehot(pick_idx);
            busy  <= 1'b1;
            hold  <= HOLD_W'(1);
          end
        end
        ST_GRANT: begin
          if (!release_now) begin
            hold <= hold + HOLD_W'(1);
          end else begin
            ptr     <= owner + 2'd1;
            // A simultaneous req drop counts as a normal release, not an expiry.
            expired <= owner_req && at_limit;
            if (pick_found) begin
              owner <= pick_idx;
              gnt   <= onehot(pick_idx);
              hold  <= HOLD_W'(1);
            end else begin
              state <= ST_IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              hold  <= '0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb4rr.sv
// Directed bench for arb4rr: reset, single grant, rotation, hold limit, expiry, reset mid-grant.
// Two instances: MAX_HOLD=8 (main) and MAX_HOLD=3 (sole-requester expiry).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_arb4rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       expired;

  logic [3:0] req3;
  logic [3:0] gnt3;
  logic [1:0] sel3;
  logic       busy3;
  logic       expired3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb4rr #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .expired(expired)
  );

  arb4rr #(.MAX_HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3),
    .gnt(gnt3), .sel(sel3), .busy(busy3), .expired(expired3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    req  = 4'b0000;
    req3 = 4'b0000;
    tick();
    tick();
    n_checks++;
    if ({gnt, sel, busy, expired} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b sel=%b busy=%b expired=%b, want all zero", gnt, sel, busy, expired);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({gnt, sel, busy, expired} !== 8'b0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got gnt=%b sel=%b busy=%b expired=%b, want all zero", c, gnt, sel, busy, expired);
      end
    end
  endtask

  task automatic test_single_grant;
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_grant_c%0d: got gnt=%b sel=%b busy=%b, want 0100 10 1", c, gnt, sel, busy);
      end
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%b busy=%b sel=%b, want 0000 0 10", gnt, busy, sel);
    end
  endtask

  task automatic test_rotation;
    logic [1:0] order [4];
    order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd1; order[3] = 2'd2;
    req = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        n_checks++;
        if (gnt !== (4'b0001 << order[i]) || sel !== order[i] || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL rotation_%0d_c%0d: got gnt=%b sel=%0d busy=%b, want owner %0d", i, c, gnt, sel, busy, order[i]);
        end
        if (c == 0) tick();
      end
      req[order[i]] = 1'b0;
      tick();
    end
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rotation_end: got gnt=%b busy=%b, want 0000 0", gnt, busy);
    end
  endtask

  task automatic test_hold_limit;
    req = 4'b0011;
    tick();
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if (gnt !== 4'b0001 || expired !== 1'b0) begin
        n_fail++;
        $display("FAIL hold0_c%0d: got gnt=%b expired=%b, want 0001 0", k, gnt, expired);
      end
      if (k < 8) tick();
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || expired !== 1'b1) begin
      n_fail++;
      $display("FAIL expire_to_1: got gnt=%b expired=%b, want 0010 1", gnt, expired);
    end
    for (int k = 2; k <= 8; k++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0010 || expired !== 1'b0) begin
        n_fail++;
        $display("FAIL hold1_c%0d: got gnt=%b expired=%b, want 0010 0", k, gnt, expired);
      end
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || expired !== 1'b1) begin
      n_fail++;
      $display("FAIL expire_to_0: got gnt=%b expired=%b, want 0001 1", gnt, expired);
    end
    req = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drain: got gnt=%b busy=%b expired=%b, want 0000 0 0", gnt, busy, expired);
    end
  endtask

  task automatic test_sole_expiry;
    req3 = 4'b1000;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (gnt3 !== 4'b1000 || sel3 !== 2'd3 || expired3 !== ((i > 0) && (i % 3 == 0))) begin
        n_fail++;
        $display("FAIL sole_c%0d: got gnt=%b sel=%0d expired=%b, want 1000 3 %0d", i, gnt3, sel3, expired3, (i > 0) && (i % 3 == 0));
      end
    end
    // Request drops exactly when the limit is reached: plain release, no expiry.
    req3 = 4'b0000;
    tick();
    n_checks++;
    if (gnt3 !== 4'b0000 || busy3 !== 1'b0 || expired3 !== 1'b0) begin
      n_fail++;
      $display("FAIL sole_drop_at_limit: got gnt=%b busy=%b expired=%b, want 0000 0 0", gnt3, busy3, expired3);
    end
  endtask

  task automatic test_reset_mid_grant;
    // Leave ptr at 2 so a missed ptr reset would pick requester 3 afterwards.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_fail++;
      $display("FAIL premid_grant: got gnt=%b sel=%0d, want 0010 1", gnt, sel);
    end
    req = 4'b1010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_fail++;
      $display("FAIL nonowner_change: got gnt=%b sel=%0d, want 0010 1", gnt, sel);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got gnt=%b sel=%b busy=%b expired=%b, want 0000 00 0 0", gnt, sel, busy, expired);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_fail++;
      $display("FAIL post_reset_ptr: got gnt=%b sel=%0d, want 0010 1", gnt, sel);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    req3 = 4'b0000;
    test_reset();
    test_single_grant();
    test_rotation();
    test_hold_limit();
    test_sole_expiry();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
